// File: rtl/posit_encoder.sv
// posit_encoder: packs a signed combined scale factor, sign and fraction into an
// N-bit posit. The regime is emitted serially, then the word is rounded to nearest-even.
`default_nettype none

module posit_encoder #(
  parameter int N        = 32,
  parameter int ES       = 3,
  parameter int K_BITS   = 6,
  parameter int MAX_BITS = ES + K_BITS,
  parameter int FRAC_W   = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic signed [MAX_BITS:0]   exp_raw,
  input  logic                       sign_in,
  input  logic        [FRAC_W-1:0]   frac_in,
  input  logic                       NaR_in,
  input  logic                       zero_in,
  output logic        [N-1:0]        posit_out,
  output logic                       busy,
  output logic                       done
);

  localparam int KW    = K_BITS + ES + 1;
  localparam int CNT_W = $clog2(N);
  localparam int STR_W = N - 1 + ES + FRAC_W;

  localparam logic signed [KW-1:0] K_SAT_HI = KW'(N - 2);
  localparam logic signed [KW-1:0] K_SAT_LO = KW'(-(N - 1));

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPLIT  = 3'd1,
    S_REGIME = 3'd2,
    S_PACK   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic signed [MAX_BITS:0] exp_q, exp_d;
  logic                     sign_q, sign_d;
  logic [FRAC_W-1:0]        frac_q, frac_d;
  logic                     nar_q, nar_d;
  logic                     zero_q, zero_d;
  logic                     neg_q, neg_d;
  logic [CNT_W-1:0]         rl_q, rl_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N-2:0]             regime_q, regime_d;
  logic [N-2:0]             body_q, body_d;
  logic                     guard_q, guard_d;
  logic                     sticky_q, sticky_d;
  logic [N-1:0]             result_q, result_d;
  logic [N-1:0]             posit_q, posit_d;
  logic                     done_q, done_d;

  logic signed [KW-1:0]     k;
  logic [CNT_W-1:0]         rl;
  logic                     last;
  logic                     rbit;
  logic [CNT_W-1:0]         shamt;
  logic [STR_W-1:0]         str;
  logic                     round_up;
  logic [N-2:0]             body_r;
  logic [N-1:0]             mag;

  assign k     = exp_q >>> ES;
  // Truncation is harmless: rl is only used when k is inside the non-saturating range.
  assign rl    = k[KW-1] ? CNT_W'(1 - int'(k)) : CNT_W'(int'(k) + 2);
  assign last  = (cnt_q == CNT_W'(1));
  assign rbit  = neg_q ? last : ~last;

  // Left-justify {regime, e, frac}; bits shifted in from the right are the zero tail.
  assign shamt = CNT_W'(N - 1) - rl_q;
  assign str   = {regime_q, exp_q[ES-1:0], frac_q} << shamt;

  assign round_up = guard_q & (sticky_q | body_q[0]) & ~(&body_q);
  assign body_r   = body_q + {{(N-2){1'b0}}, round_up};
  assign mag      = {1'b0, body_r};

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    frac_d   = frac_q;
    nar_d    = nar_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    rl_d     = rl_q;
    cnt_d    = cnt_q;
    regime_d = regime_q;
    body_d   = body_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    result_d = result_q;
    posit_d  = posit_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = exp_raw;
          sign_d  = sign_in;
          frac_d  = frac_in;
          nar_d   = NaR_in;
          zero_d  = zero_in;
          state_d = S_SPLIT;
        end
      end
      S_SPLIT: begin
        neg_d    = k[KW-1];
        rl_d     = rl;
        cnt_d    = rl;
        regime_d = '0;
        state_d  = S_REGIME;
        // Saturated results are fixed words; sign is not applied on this path.
        if (nar_q) begin
          result_d = {1'b1, {(N-1){1'b0}}};
          state_d  = S_DONE;
        end else if (zero_q) begin
          result_d = '0;
          state_d  = S_DONE;
        end else if (k >= K_SAT_HI) begin
          result_d = {1'b0, {(N-1){1'b1}}};
          state_d  = S_DONE;
        end else if (k <= K_SAT_LO) begin
          result_d = N'(1);
          state_d  = S_DONE;
        end
      end
      S_REGIME: begin
        regime_d = {regime_q[N-3:0], rbit};
        cnt_d    = cnt_q - CNT_W'(1);
        if (last) state_d = S_PACK;
      end
      S_PACK: begin
        body_d   = str[STR_W-1 -: N-1];
        guard_d  = str[STR_W-N];
        sticky_d = |str[STR_W-N-1:0];
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        result_d = sign_q ? (~mag + N'(1)) : mag;
        state_d  = S_DONE;
      end
      S_DONE: begin
        posit_d = result_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      frac_q   <= '0;
      nar_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      rl_q     <= '0;
      cnt_q    <= '0;
      regime_q <= '0;
      body_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= '0;
      posit_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      frac_q   <= frac_d;
      nar_q    <= nar_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      rl_q     <= rl_d;
      cnt_q    <= cnt_d;
      regime_q <= regime_d;
      body_q   <= body_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      posit_q  <= posit_d;
      done_q   <= done_d;
    end
  end

  assign posit_out = posit_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder: directed table, randomized model comparison and protocol sequences
// for posit_encoder (N=32, ES=3).
`default_nettype none

module tb_posit_encoder;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic signed [9:0] exp_raw;
  logic              sign_in;
  logic [27:0]       frac_in;
  logic              NaR_in;
  logic              zero_in;
  logic [31:0]       posit_out;
  logic              busy;
  logic              done;

  int n_vec  = 0;
  int n_fail = 0;

  posit_encoder #(.N(32), .ES(3), .K_BITS(6), .FRAC_W(28)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_raw(exp_raw),
    .sign_in(sign_in), .frac_in(frac_in), .NaR_in(NaR_in), .zero_in(zero_in),
    .posit_out(posit_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          e;
    bit          s;
    logic [27:0] f;
    bit          nar;
    bit          zr;
    logic [31:0] p;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int e, input bit s, input logic [27:0] f, input bit nar,
                     input bit zr, input logic [31:0] p, input int lat);
    vec_t v;
    v.e = e; v.s = s; v.f = f; v.nar = nar; v.zr = zr; v.p = p; v.lat = lat;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: build the posit bit string in a queue and round it, straight from the value rules.
  function automatic void model(input int E, input bit s, input logic [27:0] f, input bit nar,
                                input bit zr, output logic [31:0] p, output int lat);
    bit q[$];
    int e, k, rl;
    logic [30:0] body;
    bit g, st;
    if (nar) begin
      p = 32'h8000_0000; lat = 2;
    end else if (zr) begin
      p = 32'h0; lat = 2;
    end else begin
      e = ((E % 8) + 8) % 8;
      k = (E - e) / 8;
      if (k >= 30) begin
        p = 32'h7FFF_FFFF; lat = 2;
      end else if (k <= -31) begin
        p = 32'h0000_0001; lat = 2;
      end else begin
        if (k >= 0) begin
          repeat (k + 1) q.push_back(1'b1);
          q.push_back(1'b0);
          rl = k + 2;
        end else begin
          repeat (-k) q.push_back(1'b0);
          q.push_back(1'b1);
          rl = 1 - k;
        end
        for (int i = 2; i >= 0; i--) q.push_back(((e >> i) & 1) != 0);
        for (int i = 27; i >= 0; i--) q.push_back(f[i]);
        for (int i = 0; i < 31; i++) body[30-i] = (i < q.size()) ? q[i] : 1'b0;
        g  = (q.size() > 31) ? q[31] : 1'b0;
        st = 1'b0;
        for (int i = 32; i < q.size(); i++) st = st | q[i];
        if (g && (st || body[0]) && (body != 31'h7FFF_FFFF)) body = body + 31'd1;
        p = {1'b0, body};
        if (s) p = 32'd0 - p;
        lat = rl + 4;
      end
    end
  endfunction

  task automatic issue(input int e, input bit s, input logic [27:0] f, input bit nar, input bit zr);
    exp_raw = 10'(e);
    sign_in = s;
    frac_in = f;
    NaR_in  = nar;
    zero_in = zr;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  // Returns cycles from the accepting edge to the cycle done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    int c;
    lat = -1;
    c = 0;
    while (lat < 0 && c < 60) begin
      @(posedge clk);
      #1;
      c++;
      if (done) lat = c;
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat, cnt, exp_lat;
    logic [31:0] exp_p, held;
    int e;
    bit s, nar, zr;
    logic [27:0] f;

    rst_n = 1'b0; start = 1'b0; exp_raw = '0; sign_in = 1'b0;
    frac_in = '0; NaR_in = 1'b0; zero_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset posit_out", posit_out, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    add(   0, 0, 28'h0,       0, 0, 32'h4000_0000,  6);
    add(  11, 0, 28'h0,       0, 0, 32'h6600_0000,  7);
    add(  -1, 1, 28'h0,       0, 0, 32'hC400_0000,  6);
    add(  -9, 0, 28'h0,       0, 0, 32'h1E00_0000,  7);
    add(   0, 1, 28'h0,       0, 0, 32'hC000_0000,  6);
    add( 300, 0, 28'h0,       0, 0, 32'h7FFF_FFFF,  2);
    add(-300, 0, 28'h0,       0, 0, 32'h0000_0001,  2);
    add(-240, 0, 28'h0,       0, 0, 32'h0000_0001, 35);
    add( 240, 0, 28'h0,       0, 0, 32'h7FFF_FFFF,  2);
    add(-248, 0, 28'h0,       0, 0, 32'h0000_0001,  2);
    add( 239, 0, 28'hFFFFFFF, 0, 0, 32'h7FFF_FFFF, 35);
    add(   0, 0, 28'hFFFFFFF, 0, 0, 32'h4400_0000,  6);
    add(   0, 0, 28'h0FFFFFF, 0, 0, 32'h4040_0000,  6);
    add(   0, 0, 28'h0000002, 0, 0, 32'h4000_0000,  6);
    add(   0, 0, 28'h0000006, 0, 0, 32'h4000_0002,  6);
    add(   0, 0, 28'h0,       1, 1, 32'h8000_0000,  2);
    add(   0, 0, 28'h0,       0, 1, 32'h0000_0000,  2);

    foreach (tbl[i]) begin
      @(negedge clk);
      issue(tbl[i].e, tbl[i].s, tbl[i].f, tbl[i].nar, tbl[i].zr);
      check("busy after start", {31'h0, busy}, 32'h1);
      wait_done(lat);
      check_int($sformatf("latency vec%0d", i), lat, tbl[i].lat);
      check($sformatf("posit vec%0d", i), posit_out, tbl[i].p);
      check("busy low with done", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;
      check("done one cycle", {31'h0, done}, 32'h0);
    end

    for (int r = 0; r < 150; r++) begin
      e   = int'($urandom_range(1023)) - 512;
      s   = 1'($urandom_range(1));
      f   = 28'($urandom);
      nar = ($urandom_range(15) == 0);
      zr  = ($urandom_range(15) == 0);
      model(e, s, f, nar, zr, exp_p, exp_lat);
      @(negedge clk);
      issue(e, s, f, nar, zr);
      wait_done(lat);
      check_int($sformatf("rand latency E=%0d", e), lat, exp_lat);
      check($sformatf("rand posit E=%0d s=%0d f=%h", e, s, f), posit_out, exp_p);
    end

    // start while busy must be ignored
    @(negedge clk);
    issue(11, 0, 28'h0, 0, 0);
    @(posedge clk);
    #1;
    exp_raw = 10'sd0; sign_in = 1'b1; NaR_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    check_int("ignored start latency", lat, 5);
    check("ignored start posit", posit_out, 32'h6600_0000);
    held = posit_out;
    count_dones(40, cnt);
    check_int("no extra done", cnt, 0);
    check("posit held", posit_out, held);
    NaR_in = 1'b0;

    // back-to-back: start in the done cycle is accepted
    @(negedge clk);
    issue(-1, 1, 28'h0, 0, 0);
    wait_done(lat);
    check("b2b first posit", posit_out, 32'hC400_0000);
    issue(11, 0, 28'h0, 0, 0);
    wait_done(lat);
    check_int("b2b second latency", lat, 7);
    check("b2b second posit", posit_out, 32'h6600_0000);

    // reset in the middle of a long regime
    @(negedge clk);
    issue(-240, 0, 28'h0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("abort posit", posit_out, 32'h0);
    check("abort done", {31'h0, done}, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, cnt);
    check_int("abort no done", cnt, 0);
    @(negedge clk);
    issue(11, 0, 28'h0, 0, 0);
    wait_done(lat);
    check_int("after abort latency", lat, 7);
    check("after abort posit", posit_out, 32'h6600_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
